// File: rtl/counter_pkg.sv
// Shared definitions for the synchronous up/down counter family.
// Holds default widths/modulus and a ceil-log2 helper for sizing callers.
`timescale 1ns/1ps
package counter_pkg;

  localparam int CNT_WIDTH_DEF = 3;
  localparam int CNT_MOD_DEF   = 8;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_up_counter_if.sv
// Control/status bundle for the up counter: the master drives en/clr/load/d,
// the counter (slave) returns the registered count, terminal count and carry.
`timescale 1ns/1ps
interface sync_up_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             carry_out;

  modport master (output en, clr, load, d, input Q, tc, carry_out);
  modport slave  (input en, clr, load, d, output Q, tc, carry_out);
endinterface

// File: rtl/upcnt_tc_detect.sv
// Terminal-count detector: tc when q equals CMP_VAL, carry_out = tc & en.
// CMP_VAL is a parameter so a down counter can reuse this with CMP_VAL = 0.
// Build option: UPCNT_SATURATE_EN forces carry_out low (counter never wraps).
`timescale 1ns/1ps
module upcnt_tc_detect #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] CMP_VAL = '1
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  output logic             tc,
  output logic             carry_out
);

  assign tc = (q == CMP_VAL);

`ifdef UPCNT_SATURATE_EN
  // A saturating counter has no wrap edge, so there is never a carry.
  logic unused_en;
  assign unused_en = en;
  assign carry_out = 1'b0;
`else
  assign carry_out = tc & en;
`endif

endmodule

// File: rtl/sync_up_counter.sv
// Synchronous modulo-MODULUS up counter with enable, sync load and sync clear.
// Edge priority: clr > load > en > hold. Loads above MODULUS-1 are clamped.
// Build option: UPCNT_SATURATE_EN makes the count stick at MODULUS-1
// instead of wrapping to 0 (only clr, load or rst leave that state).
`timescale 1ns/1ps
module sync_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEF,
  parameter int MODULUS = CNT_MOD_DEF
) (
  input  logic              clk,
  input  logic              rst,   // asynchronous, active low
  sync_up_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc;
  logic             carry_out;
  logic             d_in_range;

  // Extra bit so MODULUS == 2**WIDTH compares correctly.
  assign d_in_range = ({1'b0, bus.d} < MOD_EXT);

  upcnt_tc_detect #(
    .WIDTH   (WIDTH),
    .CMP_VAL (MAX_Q)
  ) u_tc (
    .q         (q_q),
    .en        (bus.en),
    .tc        (tc),
    .carry_out (carry_out)
  );

  // Next-state mux in priority order clr > load > en > hold.
  always_comb begin
    q_d = q_q;
    if (bus.clr) begin
      q_d = '0;
    end else if (bus.load) begin
      q_d = d_in_range ? bus.d : MAX_Q;
    end else if (bus.en) begin
      if (tc) begin
`ifdef UPCNT_SATURATE_EN
        q_d = MAX_Q;
`else
        q_d = '0;
`endif
      end else begin
        q_d = q_q + ONE;
      end
    end
  end

  // Count register; reset clears it immediately without waiting for clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign bus.Q         = q_q;
  assign bus.tc        = tc;
  assign bus.carry_out = carry_out;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: a modulo-8 and a modulo-6 instance share the
// same controls; both are checked each cycle against a modulo-arithmetic model.
`timescale 1ns/1ps
module tb_sync_up_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, load;
  logic [2:0] d;

  int n_chk = 0;
  int n_err = 0;
  int exp8  = 0;
  int exp6  = 0;
  int carries;

  sync_up_counter_if #(.WIDTH(3)) bus8 ();
  sync_up_counter_if #(.WIDTH(3)) bus6 ();

  assign bus8.en = en;  assign bus8.clr = clr;  assign bus8.load = load;  assign bus8.d = d;
  assign bus6.en = en;  assign bus6.clr = clr;  assign bus6.load = load;  assign bus6.d = d;

  sync_up_counter #(.WIDTH(3), .MODULUS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  sync_up_counter #(.WIDTH(3), .MODULUS(6)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  always #1 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference next count straight from the rules, using modulo arithmetic.
  function automatic int nxt(input int q, input int m);
    if (!rst) return 0;
    if (clr)  return 0;
    if (load) return (int'(d) < m) ? int'(d) : m - 1;
    if (en) begin
`ifdef UPCNT_SATURATE_EN
      return (q == m - 1) ? q : q + 1;
`else
      return (q + 1) % m;
`endif
    end
    return q;
  endfunction

  function automatic int exp_carry(input int q, input int m);
`ifdef UPCNT_SATURATE_EN
    return 0;
`else
    return (rst && en && q == m - 1) ? 1 : 0;
`endif
  endfunction

  task automatic check_all();
    chk("q8",     32'(bus8.Q), exp8);
    chk("tc8",    32'(bus8.tc), (exp8 == 7) ? 1 : 0);
    chk("carry8", 32'(bus8.carry_out), exp_carry(exp8, 8));
    chk("q6",     32'(bus6.Q), exp6);
    chk("tc6",    32'(bus6.tc), (exp6 == 5) ? 1 : 0);
    chk("carry6", 32'(bus6.carry_out), exp_carry(exp6, 6));
    chk("q6_range", 32'(bus6.Q < 3'd6), 1);
  endtask

  // One clock: model advances on the edge, outputs checked on the falling edge.
  task automatic step();
    @(posedge clk);
    exp8 = nxt(exp8, 8);
    exp6 = nxt(exp6, 6);
    @(negedge clk);
    check_all();
    if (bus8.carry_out === 1'b1) carries++;
  endtask

  task automatic drive(input logic c, input logic l, input logic [2:0] dv, input logic e);
    clr = c; load = l; d = dv; en = e;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'd0, 1);
    #0.2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset state, with en already high: tc and carry must stay low.
    check_all();
    chk("rst_q8", 32'(bus8.Q), 0);
    chk("rst_carry8", 32'(bus8.carry_out), 0);
    rst = 1'b1;

    // Free count from 0: one carry per 8 edges (none when saturating).
    carries = 0;
    for (int i = 0; i < 16; i++) step();
`ifdef UPCNT_SATURATE_EN
    chk("carry_count", carries, 0);
    chk("sat_hold", 32'(bus8.Q), 7);
    drive(1, 0, 3'd0, 1);
    step();
    chk("sat_clr", 32'(bus8.Q), 0);
    drive(0, 0, 3'd0, 1);
    for (int i = 0; i < 2; i++) step();
`else
    chk("carry_count", carries, 2);
    chk("wrap_q8", 32'(bus8.Q), 0);
`endif

    // Control priority.
    drive(1, 0, 3'd0, 0); step();
    drive(0, 0, 3'd0, 1);
    for (int i = 0; i < 3; i++) step();
    chk("at3", 32'(bus8.Q), 3);
    drive(1, 1, 3'd5, 1); step();
    chk("prio_clr", 32'(bus8.Q), 0);
    drive(0, 1, 3'd5, 1); step();
    chk("prio_load8", 32'(bus8.Q), 5);
    chk("prio_load6", 32'(bus6.Q), 5);
    drive(0, 1, 3'd7, 0); step();
    chk("load7_q8", 32'(bus8.Q), 7);
    chk("clamp_q6", 32'(bus6.Q), 5);

    // Enable gating at terminal count.
    drive(0, 0, 3'd0, 0); step(); step();
    chk("hold_q8", 32'(bus8.Q), 7);
    chk("hold_tc8", 32'(bus8.tc), 1);
    chk("hold_carry8", 32'(bus8.carry_out), 0);
    en = 1'b1;
    #0.2;
`ifdef UPCNT_SATURATE_EN
    chk("en_carry8", 32'(bus8.carry_out), 0);
`else
    chk("en_carry8", 32'(bus8.carry_out), 1);
`endif
    step();
`ifdef UPCNT_SATURATE_EN
    chk("en_wrap_q8", 32'(bus8.Q), 7);
`else
    chk("en_wrap_q8", 32'(bus8.Q), 0);
`endif

    // Asynchronous reset between edges at Q=4.
    drive(1, 0, 3'd0, 0); step();
    drive(0, 0, 3'd0, 1);
    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_q8", 32'(bus8.Q), 4);
    #0.4 rst = 1'b0;
    #0.2;
    exp8 = 0; exp6 = 0;
    chk("async_q8", 32'(bus8.Q), 0);
    chk("async_q6", 32'(bus6.Q), 0);
    chk("async_carry8", 32'(bus8.carry_out), 0);
    @(negedge clk);
    check_all();
    rst = 1'b1;
    step();
    chk("resume_q8", 32'(bus8.Q), 1);

    // Randomized controls.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(15) == 0), ($urandom_range(7) == 0),
            3'($urandom_range(7)), ($urandom_range(3) != 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
